// File: rtl/lock_arb_pkg.sv
// Shared definitions for the two-core lock arbiter:
// FSM encoding, owner codes and default bus widths.
package lock_arb_pkg;

   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT0  = 2'd1,
      GRANT1  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_C0   = 2'b01;
   localparam logic [1:0] OWN_C1   = 2'b10;

   // Grant state for a core index.
   function automatic state_t grant_of(input logic core);
      return core ? GRANT1 : GRANT0;
   endfunction

   // Owner code for a core index.
   function automatic logic [1:0] code_of(input logic core);
      return core ? OWN_C1 : OWN_C0;
   endfunction

endpackage

// File: rtl/lock_arbiter_if.sv
// Core-facing and memory-facing signals of the lock arbiter.
// slave = arbiter side, master = cores/memory side.
interface lock_arbiter_if
   import lock_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              need_lock0;
   logic              need_lock1;
   logic              lock0;
   logic              lock1;

   logic [ADDR_W-1:0] gaddress0;
   logic [ADDR_W-1:0] gaddress1;
   logic [DATA_W-1:0] gdata0;
   logic [DATA_W-1:0] gdata1;
   logic              gwren0;
   logic              gwren1;
   logic [DATA_W-1:0] gq0;
   logic [DATA_W-1:0] gq1;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;

   logic [1:0]        owner;
   logic              timeout;

   modport slave (
      input  need_lock0, need_lock1,
      input  gaddress0, gaddress1,
      input  gdata0, gdata1,
      input  gwren0, gwren1,
      input  mem_q,
      output lock0, lock1,
      output gq0, gq1,
      output mem_address, mem_data, mem_wren,
      output owner, timeout
   );

   modport master (
      output need_lock0, need_lock1,
      output gaddress0, gaddress1,
      output gdata0, gdata1,
      output gwren0, gwren1,
      output mem_q,
      input  lock0, lock1,
      input  gq0, gq1,
      input  mem_address, mem_data, mem_wren,
      input  owner, timeout
   );

endinterface

// File: rtl/gmem_port_mux.sv
// Steers the owning core's port onto the shared memory;
// a core without the lock can never write.
module gmem_port_mux
   import lock_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic [1:0]        owner,
   input  logic [ADDR_W-1:0] gaddress0,
   input  logic [ADDR_W-1:0] gaddress1,
   input  logic [DATA_W-1:0] gdata0,
   input  logic [DATA_W-1:0] gdata1,
   input  logic              gwren0,
   input  logic              gwren1,
   input  logic [DATA_W-1:0] mem_q,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   output logic [DATA_W-1:0] gq0,
   output logic [DATA_W-1:0] gq1
);

   // Owner selects the write port; no owner parks on core0 with writes off.
   always_comb begin
      mem_address = gaddress0;
      mem_data    = gdata0;
      mem_wren    = 1'b0;
      case (owner)
         OWN_C0: begin
            mem_address = gaddress0;
            mem_data    = gdata0;
            mem_wren    = gwren0;
         end
         OWN_C1: begin
            mem_address = gaddress1;
            mem_data    = gdata1;
            mem_wren    = gwren1;
         end
         default: begin
            mem_wren = 1'b0;
         end
      endcase
   end

   // Read data is broadcast; only the owner acts on it.
   always_comb begin
      gq0 = mem_q;
      gq1 = mem_q;
   end

endmodule

// File: rtl/lock_arbiter.sv
// Two-core mutual-exclusion lock with round-robin tie break
// and a contended-hold timeout that forces a release.
module lock_arbiter
   import lock_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int HOLD_MAX = 255
)(
   input  logic          clk,
   input  logic          rst,
   lock_arbiter_if.slave bus
);

   localparam logic [7:0] HOLD_LIM = HOLD_MAX[7:0];

   state_t     state;
   logic       last_owner;
   logic [7:0] hold_cnt;
   logic [1:0] owner_q;
   logic       timeout_q;

   logic       cur;
   logic       own_req;
   logic       oth_req;
   logic       both_req;
   logic       hold_hit;

   // Request view relative to the core currently holding the grant.
   always_comb begin
      cur      = (state == GRANT1);
      own_req  = cur ? bus.need_lock1 : bus.need_lock0;
      oth_req  = cur ? bus.need_lock0 : bus.need_lock1;
      both_req = bus.need_lock0 & bus.need_lock1;
      hold_hit = (hold_cnt == HOLD_LIM);
   end

   // Grant FSM with hold counter, owner and sticky timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         hold_cnt   <= '0;
         owner_q    <= OWN_NONE;
         timeout_q  <= 1'b0;
      end else begin
         case (state)
            IDLE, RELEASE: begin
               hold_cnt <= '0;
               if (both_req) begin
                  state   <= grant_of(~last_owner);
                  owner_q <= code_of(~last_owner);
               end else if (bus.need_lock0) begin
                  state   <= GRANT0;
                  owner_q <= OWN_C0;
               end else if (bus.need_lock1) begin
                  state   <= GRANT1;
                  owner_q <= OWN_C1;
               end else begin
                  state   <= IDLE;
                  owner_q <= OWN_NONE;
               end
            end
            GRANT0, GRANT1: begin
               if (!own_req) begin
                  state      <= RELEASE;
                  owner_q    <= OWN_NONE;
                  last_owner <= cur;
               end else if (oth_req && hold_hit) begin
                  state      <= RELEASE;
                  owner_q    <= OWN_NONE;
                  last_owner <= cur;
                  timeout_q  <= 1'b1;
               end else if (oth_req && !hold_hit) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: begin
               state   <= IDLE;
               owner_q <= OWN_NONE;
            end
         endcase
      end
   end

   // Stall whoever wants the lock but does not hold it.
   always_comb begin
      bus.lock0   = bus.need_lock0 & (state != GRANT0);
      bus.lock1   = bus.need_lock1 & (state != GRANT1);
      bus.owner   = owner_q;
      bus.timeout = timeout_q;
   end

   gmem_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux (
      .owner       (owner_q),
      .gaddress0   (bus.gaddress0),
      .gaddress1   (bus.gaddress1),
      .gdata0      (bus.gdata0),
      .gdata1      (bus.gdata1),
      .gwren0      (bus.gwren0),
      .gwren1      (bus.gwren1),
      .mem_q       (bus.mem_q),
      .mem_address (bus.mem_address),
      .mem_data    (bus.mem_data),
      .mem_wren    (bus.mem_wren),
      .gq0         (bus.gq0),
      .gq1         (bus.gq1)
   );

endmodule

// File: tb/tb_lock_arbiter.sv
// Scenario bench for lock_arbiter: per-cycle expectations are
// queued as stimulus is applied and popped at the falling edge.
module tb_lock_arbiter;
   import lock_arb_pkg::*;

   typedef struct {
      string       tag;
      logic [43:0] v;
   } exp_t;

   typedef struct packed {
      logic [3:0] in;
      logic [1:0] eo;
      logic [2:0] out;
   } row_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lock_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

   lock_arbiter #(
      .ADDR_W   (6),
      .DATA_W   (32),
      .HOLD_MAX (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        sb[$];
   logic [31:0] qsb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic        iso_on  = 1'b0;
   logic        iso_hit = 1'b0;

   // Record any write to address 3 while the isolation scenario runs.
   always @(negedge clk) begin
      if (iso_on && bus.mem_wren && bus.mem_address == 6'd3)
         iso_hit <= 1'b1;
   end

   function automatic row_t R(input logic [3:0] in,
                              input logic [1:0] eo,
                              input logic [2:0] out);
      row_t r;
      r.in  = in;
      r.eo  = eo;
      r.out = out;
      return r;
   endfunction

   function automatic logic [43:0] observe();
      return {bus.owner, bus.lock0, bus.lock1, bus.mem_wren,
              bus.timeout, bus.mem_address, bus.mem_data};
   endfunction

   task automatic drive(input logic [3:0] in);
      bus.need_lock0 = in[3];
      bus.need_lock1 = in[2];
      bus.gwren0     = in[1];
      bus.gwren1     = in[0];
   endtask

   // Expected outputs for a given owner/lock/timeout, port mux modelled.
   function automatic void push_exp(input string tag,
                                    input logic [1:0] eo,
                                    input logic [2:0] out);
      exp_t        e;
      logic        wr;
      logic [5:0]  ad;
      logic [31:0] da;
      wr = (eo == OWN_C0) ? bus.gwren0 :
           (eo == OWN_C1) ? bus.gwren1 : 1'b0;
      ad = (eo == OWN_C1) ? bus.gaddress1 : bus.gaddress0;
      da = (eo == OWN_C1) ? bus.gdata1 : bus.gdata0;
      e.tag = tag;
      e.v   = {eo, out[2], out[1], wr, out[0], ad, da};
      sb.push_back(e);
   endfunction

   task automatic step(input row_t r, input string tag);
      @(posedge clk);
      #1;
      drive(r.in);
      push_exp(tag, r.eo, r.out);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(4'b0000);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      exp_t        e;
      logic [43:0] got;
      rst = 1'b0;
      drive(4'b0000);
      repeat (2) @(posedge clk);
      #1;
      drive(4'b1110);
      push_exp("rst_lock_both", OWN_NONE, 3'b110);
      @(negedge clk);
      got = observe();
      e = sb.pop_front();
      n_chk++;
      if (got !== e.v) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", e.tag, got, e.v);
      end
      drive(4'b0110);
      push_exp("rst_lock1_only", OWN_NONE, 3'b010);
      #1;
      got = observe();
      e = sb.pop_front();
      n_chk++;
      if (got !== e.v) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", e.tag, got, e.v);
      end
      @(negedge clk);
      drive(4'b0000);
      rst = 1'b1;
   endtask

   task automatic test_readback();
      logic [31:0] q;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         q = $urandom;
         bus.mem_q = q;
         qsb.push_back(q);
         #1;
         q = qsb.pop_front();
         n_chk++;
         if (bus.gq0 !== q) begin
            n_fail++;
            $display("FAIL gq0[%0d]: got %h want %h", i, bus.gq0, q);
         end
         n_chk++;
         if (bus.gq1 !== q) begin
            n_fail++;
            $display("FAIL gq1[%0d]: got %h want %h", i, bus.gq1, q);
         end
      end
   endtask

   task automatic test_contention();
      row_t        rows[$];
      exp_t        e;
      logic [43:0] got;
      do_reset();
      rows.push_back(R(4'b1100, OWN_NONE, 3'b110));
      rows.push_back(R(4'b1100, OWN_C0,   3'b010));
      rows.push_back(R(4'b0100, OWN_C0,   3'b010));
      rows.push_back(R(4'b0100, OWN_NONE, 3'b010));
      rows.push_back(R(4'b0100, OWN_C1,   3'b000));
      rows.push_back(R(4'b0000, OWN_C1,   3'b000));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b000));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b000));
      foreach (rows[i]) begin
         step(rows[i], $sformatf("contend[%0d]", i));
         got = observe();
         e = sb.pop_front();
         n_chk++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_single();
      row_t        rows[$];
      exp_t        e;
      logic [43:0] got;
      rows.push_back(R(4'b1010, OWN_NONE, 3'b100));
      rows.push_back(R(4'b1010, OWN_C0,   3'b000));
      rows.push_back(R(4'b1010, OWN_C0,   3'b000));
      rows.push_back(R(4'b0000, OWN_C0,   3'b000));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b000));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b000));
      foreach (rows[i]) begin
         step(rows[i], $sformatf("single[%0d]", i));
         got = observe();
         e = sb.pop_front();
         n_chk++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_round_robin();
      row_t        rows[$];
      exp_t        e;
      logic [43:0] got;
      rows.push_back(R(4'b1100, OWN_NONE, 3'b110));
      rows.push_back(R(4'b1100, OWN_C1,   3'b100));
      rows.push_back(R(4'b1000, OWN_C1,   3'b100));
      rows.push_back(R(4'b1000, OWN_NONE, 3'b100));
      rows.push_back(R(4'b0000, OWN_C0,   3'b000));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b000));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b000));
      foreach (rows[i]) begin
         step(rows[i], $sformatf("rr[%0d]", i));
         got = observe();
         e = sb.pop_front();
         n_chk++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_isolation();
      row_t        rows[$];
      exp_t        e;
      logic [43:0] got;
      bus.gaddress0 = 6'd3;
      iso_hit = 1'b0;
      iso_on  = 1'b1;
      rows.push_back(R(4'b0110, OWN_NONE, 3'b010));
      rows.push_back(R(4'b0110, OWN_C1,   3'b000));
      rows.push_back(R(4'b0111, OWN_C1,   3'b000));
      rows.push_back(R(4'b0110, OWN_C1,   3'b000));
      rows.push_back(R(4'b0010, OWN_C1,   3'b000));
      rows.push_back(R(4'b0010, OWN_NONE, 3'b000));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b000));
      foreach (rows[i]) begin
         step(rows[i], $sformatf("iso[%0d]", i));
         got = observe();
         e = sb.pop_front();
         n_chk++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", e.tag, got, e.v);
         end
      end
      iso_on = 1'b0;
      n_chk++;
      if (iso_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL iso_addr3: got write=%b want write=0", iso_hit);
      end
      bus.gaddress0 = 6'd5;
   endtask

   task automatic test_timeout();
      row_t        rows[$];
      exp_t        e;
      logic [43:0] got;
      rows.push_back(R(4'b1100, OWN_NONE, 3'b110));
      repeat (5) rows.push_back(R(4'b1100, OWN_C0, 3'b010));
      rows.push_back(R(4'b1100, OWN_NONE, 3'b111));
      rows.push_back(R(4'b1100, OWN_C1,   3'b101));
      rows.push_back(R(4'b1000, OWN_C1,   3'b101));
      rows.push_back(R(4'b1000, OWN_NONE, 3'b101));
      rows.push_back(R(4'b0000, OWN_C0,   3'b001));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b001));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b001));
      foreach (rows[i]) begin
         step(rows[i], $sformatf("tmo[%0d]", i));
         got = observe();
         e = sb.pop_front();
         n_chk++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_reset_midgrant();
      row_t        rows[$];
      exp_t        e;
      logic [43:0] got;
      rows.push_back(R(4'b1010, OWN_NONE, 3'b101));
      rows.push_back(R(4'b1010, OWN_C0,   3'b001));
      rows.push_back(R(4'b0000, OWN_C0,   3'b000));
      rows.push_back(R(4'b0000, OWN_NONE, 3'b000));
      foreach (rows[i]) begin
         step(rows[i], $sformatf("midrst[%0d]", i));
         got = observe();
         e = sb.pop_front();
         n_chk++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", e.tag, got, e.v);
         end
         if (i == 1) begin
            #2;
            rst = 1'b0;
            push_exp("midrst_async", OWN_NONE, 3'b100);
            #1;
            got = observe();
            e = sb.pop_front();
            n_chk++;
            if (got !== e.v) begin
               n_fail++;
               $display("FAIL %s: got %h want %h", e.tag, got, e.v);
            end
            @(posedge clk);
            #1;
            push_exp("midrst_held", OWN_NONE, 3'b100);
            got = observe();
            e = sb.pop_front();
            n_chk++;
            if (got !== e.v) begin
               n_fail++;
               $display("FAIL %s: got %h want %h", e.tag, got, e.v);
            end
            @(negedge clk);
            rst = 1'b1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish by 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      drive(4'b0000);
      bus.gaddress0 = 6'd5;
      bus.gdata0    = 32'hDEADBEEF;
      bus.gaddress1 = 6'd9;
      bus.gdata1    = 32'hCAFEF00D;
      bus.mem_q     = 32'h0;
      test_reset();
      test_readback();
      test_contention();
      test_single();
      test_round_robin();
      test_isolation();
      test_timeout();
      test_reset_midgrant();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
